q1_word_arbiter: RTL and testbench
==================================

Q1_WORD_ARBITER -- requirements
Module: q1_word_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesters sharing the q1 lookup (2..8).
REQ-002 SHALL have parameter IDW, default $clog2(NREQ), meaning the width of rsp_id.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid  input  NREQ  bit i means requester i offers a 32-bit word.
REQ-006 SHALL have port req_word  input  NREQ*32  word of requester i at bits [32i+31:32i].
REQ-007 SHALL have port req_ready  output  NREQ  bit i means the word of requester i is accepted this cycle.
REQ-008 SHALL have port rsp_valid  output  1  the transformed word is present.
REQ-009 SHALL have port rsp_word  output  32  q1 applied bytewise to the accepted word.
REQ-010 SHALL have port rsp_id  output  IDW  index of the requester that owns rsp_word.
REQ-011 SHALL have port rsp_ready  input  1  the consumer takes the response.

Function
REQ-012 SHALL use one three-state FSM: IDLE, LOOKUP, RESP.
REQ-013 In IDLE, SHALL grant exactly one valid requester by round-robin, searching upward from (last_grant+1) mod NREQ; last_grant SHALL reset to NREQ-1, so requester 0 has first priority.
REQ-014 SHALL drive req_ready[g] high combinationally only in IDLE and only for the granted g with req_valid[g]=1; all other req_ready bits SHALL be 0.
REQ-015 On an IDLE edge with req_valid[g]&req_ready[g], SHALL latch req_word[g] and g, update last_grant to g, clear byte counter, and enter LOOKUP.
REQ-016 In LOOKUP, SHALL present byte[cnt] (cnt 0..3, LSB first) to the single q1 lookup and register its output into result byte cnt at the edge.
REQ-017 SHALL leave LOOKUP for RESP at the edge where cnt=3; cnt SHALL be 2 bits and wrap to 0.
REQ-018 Latency: acceptance at edge E0 SHALL give rsp_valid=1 in the cycle after edge E4; there are exactly 4 LOOKUP cycles.
REQ-019 In RESP, SHALL hold rsp_valid=1 with rsp_word and rsp_id stable until an edge with rsp_ready=1, then return to IDLE.
REQ-020 SHALL NOT accept a new request in the same cycle as a response handshake; the minimum issue interval is 6 cycles.
REQ-021 Requests that drop req_valid before being granted SHALL be ignored; no request is queued internally.
REQ-022 rsp_valid SHALL be 0 in IDLE and LOOKUP; rsp_word and rsp_id keep their last value outside RESP.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, cnt=0, last_grant=NREQ-1, rsp_valid=0, rsp_word=0, rsp_id=0, and the latched word=0.
REQ-024 Reset during LOOKUP or RESP SHALL discard the in-flight word with no response issued.
REQ-025 After rst deassertion, the first acceptance SHALL be possible in the first cycle with a valid request.

Structure
REQ-026 A shared package SHALL hold the FSM state enum (IDLE, LOOKUP, RESP) and the constant BYTES_PER_WORD=4.
REQ-027 SHALL instantiate exactly one existing q1 permutation lookup as the only sub-module; its 8-bit input is byte[cnt] and its 8-bit output is the lookup result; it is combinational.

Verification
REQ-028 Single request, req0 word 0x03020100, rsp_ready=1 -> rsp_word=0xF4C6F375, rsp_id=0, rsp_valid rises 5 cycles after acceptance.
REQ-029 req2 word 0xFFFFFF25 -> rsp_word=0x91919100, rsp_id=2.
REQ-030 All four req_valid held high after reset, distinct words -> responses in id order 0,1,2,3,0, with each accept 6 cycles apart.
REQ-031 rsp_ready low for 10 cycles in RESP -> rsp_valid, rsp_word and rsp_id stable; all req_ready=0 throughout.
REQ-032 rst pulse during the 2nd LOOKUP cycle -> outputs zero at once, no response for that word, and the next request is granted starting from requester 0.

Source files
------------

// File: rtl/q1_word_arbiter_pkg.sv
// Shared definitions for the q1 word arbiter: FSM states and word geometry.
package q1_word_arbiter_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESP
  } state_t;

endpackage

// File: rtl/q1_word_arbiter_q1.sv
// Twofish q1 byte permutation, purely combinational. Built from the four
// 4-bit t-boxes rather than a 256-entry table; the result is identical.
module q1_word_arbiter_q1 (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // t-boxes, element 0 in the least significant nibble
  localparam logic [15:0][3:0] T0 = 64'h5CA04913E67FDB82;
  localparam logic [15:0][3:0] T1 = 64'h809F5AD673C4B2E1;
  localparam logic [15:0][3:0] T2 = 64'hF3B28DE0A96157C4;
  localparam logic [15:0][3:0] T3 = 64'hA802F746ED3C159B;

  logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3, a4, b4;

  // two mixing rounds, each followed by a t-box substitution per nibble
  always_comb begin
    a0   = din[7:4];
    b0   = din[3:0];
    a1   = a0 ^ b0;
    b1   = a0 ^ {b0[0], b0[3:1]} ^ {a0[0], 3'b000};
    a2   = T0[a1];
    b2   = T1[b1];
    a3   = a2 ^ b2;
    b3   = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
    a4   = T2[a3];
    b4   = T3[b3];
    dout = {b4, a4};
  end

endmodule

// File: rtl/q1_word_arbiter.sv
// Round-robin arbiter feeding one shared q1 lookup. A granted 32-bit word is
// transformed one byte per cycle (LSB first) and returned with its requester id.
module q1_word_arbiter
  import q1_word_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*32-1:0] req_word,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  output logic [31:0]        rsp_word,
  output logic [IDW-1:0]     rsp_id,
  input  logic               rsp_ready
);

  state_t         state_q, state_d;
  logic [1:0]     cnt_q;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] id_q;
  logic [31:0]    word_q;
  logic [23:0]    result_q;   // bytes 0..2; byte 3 goes straight to rsp_word
  logic [IDW-1:0] gnt_idx;
  logic           gnt_hit;
  logic [IDW-1:0] cand;
  logic           accept;
  logic [7:0]     q1_in, q1_out;

  // round-robin search starting just above the last grant
  always_comb begin
    gnt_hit = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NREQ);
      if (!gnt_hit && req_valid[cand]) begin
        gnt_hit = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // ready only for the single granted requester, and only while idle
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_hit) req_ready[gnt_idx] = 1'b1;
  end

  assign accept    = (state_q == IDLE) && gnt_hit;
  assign rsp_valid = (state_q == RESP);

  // select the byte currently being looked up
  always_comb begin
    case (cnt_q)
      2'd0:    q1_in = word_q[7:0];
      2'd1:    q1_in = word_q[15:8];
      2'd2:    q1_in = word_q[23:16];
      default: q1_in = word_q[31:24];
    endcase
  end

  q1_word_arbiter_q1 u_q1 (
    .din  (q1_in),
    .dout (q1_out)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state: accept -> 4 lookup cycles -> hold response until taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOOKUP;
      LOOKUP:  if (cnt_q == 2'(BYTES_PER_WORD - 1)) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath: latch on accept, accumulate lookup bytes, publish at end of LOOKUP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      last_grant <= IDW'(NREQ - 1);
      id_q       <= '0;
      word_q     <= '0;
      result_q   <= '0;
      rsp_word   <= '0;
      rsp_id     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            word_q     <= req_word[{gnt_idx, 5'd0} +: 32];
            id_q       <= gnt_idx;
            last_grant <= gnt_idx;
            cnt_q      <= '0;
          end
        end
        LOOKUP: begin
          cnt_q <= cnt_q + 2'd1;
          case (cnt_q)
            2'd0:    result_q[7:0]   <= q1_out;
            2'd1:    result_q[15:8]  <= q1_out;
            2'd2:    result_q[23:16] <= q1_out;
            default: begin
              rsp_word <= {q1_out, result_q};
              rsp_id   <= id_q;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_q1_word_arbiter.sv
// Directed bench for q1_word_arbiter: stimulus pushes expected responses into a
// scoreboard queue; a negedge monitor pops and compares on each handshake.
module tb_q1_word_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    word;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_word;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic [31:0]        rsp_word;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_ready;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_rsp    = 0;
  int   cyc      = 0;
  int   last_acc = -1;
  int   burst_last = -1;
  bit   burst    = 1'b0;
  logic prev_rv  = 1'b0;
  exp_t exp_q[$];

  q1_word_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_word  (req_word),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_word  (rsp_word),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // monitor: latency, accept spacing, and scoreboard compare on handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (|(req_valid & req_ready)) begin
        if (burst) begin
          if (burst_last >= 0) chk("accept_interval", 64'(cyc - burst_last), 64'd6);
          burst_last = cyc;
        end
        last_acc = cyc;
      end
      if (rsp_valid && !prev_rv && last_acc >= 0)
        chk("latency", 64'(cyc - last_acc), 64'd5);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rsp: got id %0d word %h, expected no response", rsp_id, rsp_word);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_word", 64'(rsp_word), 64'(e.word));
        end
        n_rsp++;
      end
    end
    prev_rv = rsp_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] w);
    req_word[i*32 +: 32] = w;
    req_valid[i]         = 1'b1;
  endtask

  task automatic push(input int id, input logic [31:0] w);
    exp_t e;
    e.id   = IDW'(id);
    e.word = w;
    exp_q.push_back(e);
  endtask

  // wait (bounded) for requester i to be accepted, then withdraw it
  task automatic wait_accept(input int i);
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (req_valid[i] && req_ready[i]) begin ok = 1'b1; break; end
      @(posedge clk);
      #0;
    end
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout: requester %0d not accepted, expected accept", i);
    end
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int k = 0;
    while (n_rsp < n && k < 200) begin
      step();
      k++;
    end
    if (n_rsp < n) begin
      n_checks++; n_errors++;
      $display("FAIL rsp_timeout: got %0d responses, expected %0d", n_rsp, n);
    end
  endtask

  initial begin
    int cnt;
    rst       = 1'b1;
    req_valid = '0;
    req_word  = '0;
    rsp_ready = 1'b1;
    #12;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_word", 64'(rsp_word), 64'd0);
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    step();
    rst = 1'b0;

    // single request from 0; first acceptance immediately possible
    set_req(0, 32'h03020100);
    push(0, 32'hF4C6F375);
    #1;
    chk("first_grant", 64'(req_ready), 64'h1);
    wait_accept(0);
    wait_rsp(1);

    // request from 2
    step();
    set_req(2, 32'hFFFFFF25);
    push(2, 32'h91919100);
    wait_accept(2);
    wait_rsp(2);

    // all four held after reset: ids 0,1,2,3,0, accepts 6 cycles apart
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 32'h03020100);
    set_req(1, 32'h00010203);
    set_req(2, 32'hFFFFFF25);
    set_req(3, 32'h25FF0001);
    push(0, 32'hF4C6F375);
    push(1, 32'h75F3C6F4);
    push(2, 32'h91919100);
    push(3, 32'h009175F3);
    push(0, 32'hF4C6F375);
    burst = 1'b1;
    cnt   = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (|(req_valid & req_ready)) cnt++;
      if (cnt == 5) break;
      @(posedge clk);
      #0;
    end
    chk("burst_accepts", 64'(cnt), 64'd5);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_rsp(7);
    burst = 1'b0;

    // consumer stalls 10 cycles: response stable, nothing else granted
    step();
    rsp_ready = 1'b0;
    set_req(1, 32'h00010203);
    push(1, 32'h75F3C6F4);
    wait_accept(1);
    for (int k = 0; k < 20 && !rsp_valid; k++) step();
    set_req(0, 32'h25FF0001);
    push(0, 32'h009175F3);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("stall_rsp_word", 64'(rsp_word), 64'h75F3C6F4);
      chk("stall_rsp_id", 64'(rsp_id), 64'd1);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #0;
    end
    #1;
    rsp_ready = 1'b1;
    wait_accept(0);
    wait_rsp(9);

    // reset in the 2nd LOOKUP cycle discards the word; grant restarts at 0
    step();
    set_req(2, 32'h03020100);
    wait_accept(2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort_rsp_word", 64'(rsp_word), 64'd0);
    chk("abort_rsp_id", 64'(rsp_id), 64'd0);
    step();
    rst = 1'b0;
    set_req(0, 32'h03020100);
    set_req(3, 32'hFFFFFF25);
    push(0, 32'hF4C6F375);
    push(3, 32'h91919100);
    #1;
    chk("post_reset_grant", 64'(req_ready), 64'h1);
    wait_accept(0);
    wait_accept(3);
    wait_rsp(11);
    for (int k = 0; k < 20; k++) step();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("total_responses", 64'(n_rsp), 64'd11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
